// File: rtl/serial_parity_checker_if.sv
// serial_parity_checker_if
// Groups the frame handshake and result signals of serial_parity_checker.
//   master : frame producer   (drives start, abort, bit_in, bit_valid)
//   slave  : the checker      (drives busy, data_out, parity_calc,
//                              parity_err, frame_valid)
// Clock and reset are kept as plain module ports, not part of the bundle.
interface serial_parity_checker_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  abort;
    logic                  bit_in;
    logic                  bit_valid;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  parity_calc;
    logic                  parity_err;
    logic                  frame_valid;

    modport master (
        output start, abort, bit_in, bit_valid,
        input  busy, data_out, parity_calc, parity_err, frame_valid
    );

    modport slave (
        input  start, abort, bit_in, bit_valid,
        output busy, data_out, parity_calc, parity_err, frame_valid
    );
endinterface

// File: rtl/serial_parity_checker.sv
// serial_parity_checker
// Receives a serial frame of DATA_WIDTH data bits (LSB first) followed by a
// single parity bit, accumulates the running XOR of the data bits and
// reports the assembled word together with the expected parity and an
// error flag once the parity bit arrives.
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_parity_checker_if.slave
//            in  : start, abort, bit_in, bit_valid
//            out : busy, data_out, parity_calc, parity_err, frame_valid
// All outputs come straight from registers.
module serial_parity_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_parity_checker_if.slave  bus
);
    localparam int   CW      = $clog2(DATA_WIDTH) + 1;
    localparam logic ODD_BIT = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  acc;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  calc_q;
    logic                  err_q;
    logic                  frame_valid_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Abort outranks every other input, so a start or a
    // bit arriving in the same cycle as abort is simply lost.
    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (bus.bit_valid && (count == CW'(DATA_WIDTH - 1))) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    if (bus.bit_valid) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: bit collection, running XOR and the result registers.
    // The result registers only change on a completed frame, so an abort
    // leaves the previous word and flags visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            shift_reg     <= '0;
            acc           <= 1'b0;
            data_q        <= '0;
            calc_q        <= ODD_BIT;
            err_q         <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            if (bus.abort) begin
                if (state != IDLE) begin
                    count <= '0;
                    acc   <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            count <= '0;
                            acc   <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (bus.bit_valid) begin
                            // Decoded write keeps the index width exact
                            // for any DATA_WIDTH.
                            for (int i = 0; i < DATA_WIDTH; i++) begin
                                if (count == CW'(i)) begin
                                    shift_reg[i] <= bus.bit_in;
                                end
                            end
                            acc   <= acc ^ bus.bit_in;
                            count <= count + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (bus.bit_valid) begin
                            data_q        <= shift_reg;
                            calc_q        <= acc ^ ODD_BIT;
                            err_q         <= bus.bit_in ^ acc ^ ODD_BIT;
                            frame_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        count <= '0;
                        acc   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.data_out    = data_q;
    assign bus.parity_calc = calc_q;
    assign bus.parity_err  = err_q;
    assign bus.frame_valid = frame_valid_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker
// Drives one even-parity and one odd-parity serial_parity_checker with the
// same serial stimulus. Expected results are queued per instance when a
// frame is driven and compared by a monitor whenever frame_valid pulses.
module tb_serial_parity_checker;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;

    always #5 clk = ~clk;

    serial_parity_checker_if #(.DATA_WIDTH(DW)) even_bus ();
    serial_parity_checker_if #(.DATA_WIDTH(DW)) odd_bus ();

    assign even_bus.start     = start;
    assign even_bus.abort     = abort;
    assign even_bus.bit_in    = bit_in;
    assign even_bus.bit_valid = bit_valid;
    assign odd_bus.start      = start;
    assign odd_bus.abort      = abort;
    assign odd_bus.bit_in     = bit_in;
    assign odd_bus.bit_valid  = bit_valid;

    serial_parity_checker #(.DATA_WIDTH(DW), .ODD_PARITY(0)) dut_even (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (even_bus)
    );

    serial_parity_checker #(.DATA_WIDTH(DW), .ODD_PARITY(1)) dut_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (odd_bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          calc;
        logic          err;
    } exp_t;

    typedef struct {
        logic [DW-1:0] word;
        logic          pbit;
        int            gap_max;
        logic          even_calc;
        logic          even_err;
        logic          odd_calc;
        logic          odd_err;
    } vec_t;

    exp_t even_q[$];
    exp_t odd_q[$];
    exp_t even_e;
    exp_t odd_e;
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic b, input int gap);
        repeat (gap) tick();
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Full frame: start pulse, DW data bits LSB first, then the parity bit.
    task automatic applyStimulus(input logic [DW-1:0] word, input logic pbit,
                                 input int gap_max);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DW; i++) begin
            sendBit(word[i], $urandom_range(0, gap_max));
        end
        sendBit(pbit, $urandom_range(0, gap_max));
    endtask

    task automatic pushExpect(input logic [DW-1:0] word, input logic pbit);
        logic x;
        x = ^word;
        even_q.push_back('{word, x, pbit ^ x});
        odd_q.push_back('{word, ~x, ~(pbit ^ x)});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy even"}, 32'(even_bus.busy), 32'd0);
        checkOutput({tag, " busy odd"}, 32'(odd_bus.busy), 32'd0);
        checkOutput({tag, " data_out even"}, 32'(even_bus.data_out), 32'd0);
        checkOutput({tag, " data_out odd"}, 32'(odd_bus.data_out), 32'd0);
        checkOutput({tag, " parity_calc even"}, 32'(even_bus.parity_calc), 32'd0);
        checkOutput({tag, " parity_calc odd"}, 32'(odd_bus.parity_calc), 32'd1);
        checkOutput({tag, " parity_err even"}, 32'(even_bus.parity_err), 32'd0);
        checkOutput({tag, " parity_err odd"}, 32'(odd_bus.parity_err), 32'd0);
        checkOutput({tag, " frame_valid even"}, 32'(even_bus.frame_valid), 32'd0);
        checkOutput({tag, " frame_valid odd"}, 32'(odd_bus.frame_valid), 32'd0);
    endtask

    task automatic checkBusy(input string tag, input logic exp_busy);
        checkOutput({tag, " busy even"}, 32'(even_bus.busy), 32'(exp_busy));
        checkOutput({tag, " busy odd"}, 32'(odd_bus.busy), 32'(exp_busy));
    endtask

    // Scoreboard monitor: every frame_valid pulse must match the oldest
    // queued expectation; a pulse with nothing queued is itself an error.
    always @(negedge clk) begin
        if (even_bus.frame_valid === 1'b1) begin
            if (even_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected frame_valid even actual=1 expected=0");
            end else begin
                even_e = even_q.pop_front();
                checkOutput("even data_out", 32'(even_bus.data_out), 32'(even_e.data));
                checkOutput("even parity_calc", 32'(even_bus.parity_calc), 32'(even_e.calc));
                checkOutput("even parity_err", 32'(even_bus.parity_err), 32'(even_e.err));
            end
        end
        if (odd_bus.frame_valid === 1'b1) begin
            if (odd_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected frame_valid odd actual=1 expected=0");
            end else begin
                odd_e = odd_q.pop_front();
                checkOutput("odd data_out", 32'(odd_bus.data_out), 32'(odd_e.data));
                checkOutput("odd parity_calc", 32'(odd_bus.parity_calc), 32'(odd_e.calc));
                checkOutput("odd parity_err", 32'(odd_bus.parity_err), 32'(odd_e.err));
            end
        end
    end

    initial begin
        //           word   pbit gap  eCalc eErr  oCalc oErr
        vecs[0] = '{8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{8'h07, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state.
        #7;
        checkResetValues("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Table-driven frames, sent back to back.
        for (int v = 0; v < 6; v++) begin
            even_q.push_back('{vecs[v].word, vecs[v].even_calc, vecs[v].even_err});
            odd_q.push_back('{vecs[v].word, vecs[v].odd_calc, vecs[v].odd_err});
            applyStimulus(vecs[v].word, vecs[v].pbit, vecs[v].gap_max);
            checkBusy($sformatf("vec%0d after frame", v), 1'b0);
        end

        // Back-to-back: second start lands in the frame_valid cycle.
        pushExpect(8'h01, 1'b1);
        pushExpect(8'h02, 1'b1);
        applyStimulus(8'h01, 1'b1, 0);
        checkOutput("b2b frame_valid cycle", 32'(even_bus.frame_valid), 32'd1);
        applyStimulus(8'h02, 1'b1, 1);

        // Abort after 4 data bits: results keep the 0x02 frame values.
        start = 1'b1;
        tick();
        start = 1'b0;
        sendBit(1'b1, 0);
        sendBit(1'b0, 1);
        sendBit(1'b1, 0);
        sendBit(1'b1, 2);
        checkBusy("mid frame", 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        checkBusy("after abort", 1'b0);
        checkOutput("abort hold data even", 32'(even_bus.data_out), 32'h02);
        checkOutput("abort hold data odd", 32'(odd_bus.data_out), 32'h02);
        checkOutput("abort hold calc even", 32'(even_bus.parity_calc), 32'd1);
        checkOutput("abort hold err even", 32'(even_bus.parity_err), 32'd0);
        checkOutput("abort hold calc odd", 32'(odd_bus.parity_calc), 32'd0);
        checkOutput("abort hold err odd", 32'(odd_bus.parity_err), 32'd1);
        pushExpect(8'h3C, 1'b0);
        applyStimulus(8'h3C, 1'b0, 1);

        // Asynchronous reset between clock edges after 5 data bits.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) sendBit(1'b1, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkResetValues("async reset");
        #12 rst_n = 1'b1;
        tick();
        pushExpect(8'h81, 1'b0);
        applyStimulus(8'h81, 1'b0, 2);

        // Abort together with a bit: bit dropped, frame gone, and the
        // following stray bits in IDLE must not complete anything.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) sendBit(1'b0, 0);
        abort     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        abort     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        checkBusy("abort with bit", 1'b0);
        for (int i = 0; i < DW + 1; i++) sendBit(1'b1, 0);

        // Abort and start together in IDLE: stays idle.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checkBusy("abort plus start", 1'b0);
        for (int i = 0; i < DW + 1; i++) sendBit(1'b0, 0);
        checkBusy("idle bits", 1'b0);

        // Start mid-frame is ignored; the frame completes as 0x5A.
        pushExpect(8'h5A, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) sendBit(8'h5A >> i, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 3; i < DW; i++) sendBit(8'h5A >> i, 1);
        sendBit(1'b0, 0);
        checkBusy("start mid frame", 1'b0);

        // A bit in the start cycle is ignored; the frame is 0x00.
        pushExpect(8'h00, 1'b0);
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        for (int i = 0; i < DW; i++) sendBit(1'b0, 0);
        sendBit(1'b0, 0);

        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 20 && (even_q.size() != 0 || odd_q.size() != 0); i++) begin
            tick();
        end
        checkOutput("pending frames even", 32'(even_q.size()), 32'd0);
        checkOutput("pending frames odd", 32'(odd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
